// File: rtl/keycode_move_ctrl.sv
// keycode_move_ctrl: turns the SoC's 16-bit HID keycode word into maze
// step events with typematic auto-repeat, a one-entry valid/ready output
// slot and a saturating count of steps lost to a stalled consumer.
module keycode_move_ctrl #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter logic [7:0]  KEY_UP       = 8'h1A,
  parameter logic [7:0]  KEY_LEFT     = 8'h04,
  parameter logic [7:0]  KEY_DOWN     = 8'h16,
  parameter logic [7:0]  KEY_RIGHT    = 8'h07
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [15:0] keycode,
  input  logic        move_ready,
  output logic        move_valid,
  output logic [1:0]  move_dir,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [15:0]      r_kc_q;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cur_dir;
  logic             r_valid;
  logic [1:0]       r_dir;
  logic [7:0]       r_drop;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_cur_dir_nxt;
  logic             w_step;
  logic [1:0]       w_step_dir;
  logic             w_valid_nxt;
  logic [1:0]       w_dir_nxt;
  logic [7:0]       w_drop_nxt;
  logic             w_hit0;
  logic [1:0]       w_dir0;
  logic             w_hit1;
  logic [1:0]       w_dir1;
  logic             w_act;
  logic [1:0]       w_act_dir;

  // Map one HID slot to {hit, direction}; non-direction codes miss.
  function automatic logic [2:0] decode_slot(input logic [7:0] code);
    logic [2:0] res;
    res = 3'b000;
    if (code == KEY_UP)         res = 3'b100;
    else if (code == KEY_LEFT)  res = 3'b101;
    else if (code == KEY_DOWN)  res = 3'b110;
    else if (code == KEY_RIGHT) res = 3'b111;
    return res;
  endfunction

  // Slot0 wins over slot1 when both carry a direction key.
  always_comb begin
    {w_hit0, w_dir0} = decode_slot(r_kc_q[7:0]);
    {w_hit1, w_dir1} = decode_slot(r_kc_q[15:8]);
    w_act     = w_hit0 | w_hit1;
    w_act_dir = w_hit0 ? w_dir0 : w_dir1;
  end

  // Typematic FSM: release beats direction change beats counter expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cur_dir_nxt = r_cur_dir;
    w_step        = 1'b0;
    w_step_dir    = r_cur_dir;
    case (r_state)
      S_IDLE: begin
        if (w_act) begin
          w_step        = 1'b1;
          w_step_dir    = w_act_dir;
          w_cur_dir_nxt = w_act_dir;
          w_cnt_nxt     = DELAY_LD;
          w_state_nxt   = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_act_dir != r_cur_dir) begin
          w_step        = 1'b1;
          w_step_dir    = w_act_dir;
          w_cur_dir_nxt = w_act_dir;
          w_cnt_nxt     = DELAY_LD;
          w_state_nxt   = S_DELAY;
        end else if (r_cnt == '0) begin
          w_step      = 1'b1;
          w_step_dir  = r_cur_dir;
          w_cnt_nxt   = RATE_LD;
          w_state_nxt = S_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output slot: load when empty or draining this cycle, else drop and count.
  always_comb begin
    w_valid_nxt = r_valid;
    w_dir_nxt   = r_dir;
    w_drop_nxt  = r_drop;
    if (w_step) begin
      if (!r_valid || move_ready) begin
        w_valid_nxt = 1'b1;
        w_dir_nxt   = w_step_dir;
      end else if (r_drop != 8'hFF) begin
        w_drop_nxt = r_drop + 8'd1;
      end
    end else if (r_valid && move_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_kc_q    <= '0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur_dir <= '0;
      r_valid   <= 1'b0;
      r_dir     <= '0;
      r_drop    <= '0;
    end else begin
      r_kc_q    <= keycode;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_dir <= w_cur_dir_nxt;
      r_valid   <= w_valid_nxt;
      r_dir     <= w_dir_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  assign move_valid = r_valid;
  assign move_dir   = r_dir;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_keycode_move_ctrl.sv
// Directed bench for keycode_move_ctrl with REPEAT_DELAY=8, REPEAT_RATE=4.
module tb_keycode_move_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keycode;
  logic        move_ready;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int rel;
  int q_cyc[$];
  int q_dir[$];
  int e_cyc[$];
  int e_dir[$];

  keycode_move_ctrl #(
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .keycode      (keycode),
    .move_ready   (move_ready),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_seq();
    rel = 0;
    q_cyc.delete();
    q_dir.delete();
    e_cyc.delete();
    e_dir.delete();
  endtask

  task automatic add_exp(input int c, input int d);
    e_cyc.push_back(c);
    e_dir.push_back(d);
  endtask

  // Advance n cycles, logging the relative cycle and direction of each valid.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      rel++;
      if (move_valid) begin
        q_cyc.push_back(rel);
        q_dir.push_back(int'(move_dir));
      end
    end
  endtask

  task automatic expect_steps(input string tag);
    int n;
    check($sformatf("%s_count", tag), 32'(q_cyc.size()), 32'(e_cyc.size()));
    n = (q_cyc.size() < e_cyc.size()) ? q_cyc.size() : e_cyc.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_cyc%0d", tag, i), 32'(q_cyc[i]), 32'(e_cyc[i]));
      check($sformatf("%s_dir%0d", tag, i), 32'(q_dir[i]), 32'(e_dir[i]));
    end
  endtask

  initial begin
    int bad;
    rst_n      = 1'b0;
    keycode    = 16'h001A;
    move_ready = 1'b1;

    // Reset held 3 cycles with a key present: nothing may leak out.
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("rst_valid%0d", i), 32'(move_valid), 32'd0);
      check($sformatf("rst_drop%0d", i), 32'(drop_cnt), 32'd0);
    end
    check("rst_dir", 32'(move_dir), 32'd0);
    rst_n = 1'b1;
    start_seq();
    collect(2);
    keycode = 16'h0000;
    collect(10);
    add_exp(2, 0);
    expect_steps("rst_first");

    // Held key: steps at 0, 8, 12, ... then silence after release.
    start_seq();
    keycode = 16'h0007;
    collect(30);
    keycode = 16'h0000;
    collect(15);
    add_exp(2, 3);
    add_exp(10, 3);
    add_exp(14, 3);
    add_exp(18, 3);
    add_exp(22, 3);
    add_exp(26, 3);
    add_exp(30, 3);
    expect_steps("hold");

    // Slot0 priority, then a direction change restarts the delay.
    start_seq();
    keycode = 16'h0416;
    collect(4);
    keycode = 16'h1604;
    collect(12);
    keycode = 16'h0000;
    collect(6);
    add_exp(2, 2);
    add_exp(6, 1);
    add_exp(14, 1);
    expect_steps("change");

    // Non-direction code ignored; slot1 used when slot0 misses.
    start_seq();
    keycode = 16'h2C00;
    collect(6);
    keycode = 16'h1A2C;
    collect(4);
    keycode = 16'h0000;
    collect(6);
    add_exp(8, 0);
    expect_steps("nondir");

    // Backpressure: held step stays stable while repeats are dropped.
    start_seq();
    move_ready = 1'b0;
    keycode    = 16'h0004;
    bad        = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i >= 2 && (move_valid !== 1'b1 || move_dir !== 2'd1)) bad++;
    end
    check("bp_stable_bad", 32'(bad), 32'd0);
    check("bp_dir", 32'(move_dir), 32'd1);
    keycode = 16'h0000;
    tick(4);
    check("bp_drop", 32'(drop_cnt), 32'd8);
    check("bp_valid_held", 32'(move_valid), 32'd1);
    move_ready = 1'b1;
    tick(1);
    check("bp_accept_clear", 32'(move_valid), 32'd0);
    check("bp_drop_after", 32'(drop_cnt), 32'd8);

    // Reset mid-hold: async clear, then a clean restart of the timing.
    start_seq();
    keycode = 16'h0007;
    collect(10);
    add_exp(2, 3);
    add_exp(10, 3);
    expect_steps("pre_rst");
    check("pre_rst_valid", 32'(move_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(move_valid), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_dir", 32'(move_dir), 32'd0);
    tick(2);
    rst_n = 1'b1;
    start_seq();
    collect(10);
    keycode = 16'h0000;
    collect(6);
    add_exp(2, 3);
    add_exp(10, 3);
    expect_steps("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keycode_move_ctrl.md
# keycode_move_ctrl

Converts the 16-bit USB HID keycode word exported by the Nios II SoC into discrete maze-movement step events with typematic auto-repeat. It sits directly downstream of the SoC's `keycode_export` port and feeds the maze player-position logic through a one-entry valid/ready output. It tracks key press, hold and release, and counts steps that are dropped because the consumer stalled.

## Interface
- `REPEAT_DELAY`, 25000000: cycles from initial step to first repeat (0.5 s at 50 MHz); must be ≥1.
- `REPEAT_RATE`, 5000000: cycles between subsequent repeats; must be ≥1.
- `KEY_UP`, 8'h1A: HID code for up (W).
- `KEY_LEFT`, 8'h04: HID code for left (A).
- `KEY_DOWN`, 8'h16: HID code for down (S).
- `KEY_RIGHT`, 8'h07: HID code for right (D).

Ports:
- `clk_clk` in 1: single system clock; everything is on its rising edge.
- `reset_reset_n` in 1: asynchronous active-low reset.
- `keycode` in 16: two HID key slots; slot0 = [7:0], slot1 = [15:8]; 8'h00 means no key.
- `move_ready` in 1: consumer accepts the step when `move_valid` and `move_ready` are both high.
- `move_valid` out 1: a step is held on `move_dir`.
- `move_dir` out 2: 0 up, 1 left, 2 down, 3 right.
- `drop_cnt` out 8: saturating count of step events lost to a full output slot.

## Operation
- `keycode` is registered into `kc_q` every cycle.
- Decode of `kc_q`:
  - Slot0 is checked first. If it matches a direction key, that key is the active direction.
  - Otherwise slot1 is checked.
  - If neither slot matches, there is no active direction.
  - Non-direction codes are ignored.
- The FSM has three states: IDLE, DELAY and REPEAT. A down-counter `cnt` is wide enough for max(`REPEAT_DELAY`, `REPEAT_RATE`) − 1, and `cur_dir` holds the direction being tracked.
- IDLE:
  - Active direction present: emit step(dir), `cur_dir` ← dir, `cnt` ← `REPEAT_DELAY` − 1, go to DELAY.
- DELAY and REPEAT:
  - No active direction: go to IDLE, `cnt` ← 0, no step.
  - Active direction ≠ `cur_dir`: treated as a new press. Emit step(new), `cur_dir` ← new, `cnt` ← `REPEAT_DELAY` − 1, go to DELAY.
  - `cnt` = 0: emit step(`cur_dir`), `cnt` ← `REPEAT_RATE` − 1, go to (or stay in) REPEAT.
  - Otherwise: `cnt` decrements by 1.
- Output slot:
  - A step is loaded, with `move_valid` ← 1 and `move_dir` ← dir, if the slot is empty or is being accepted in the same cycle.
  - Otherwise the step is dropped and `drop_cnt` increments, saturating at 255.
  - An accept with no new step clears `move_valid`.
  - `move_dir` is stable while `move_valid` = 1 and `move_ready` = 0.
- Reset values: `move_valid` 0, `move_dir` 0, `drop_cnt` 0, `kc_q` 0, state IDLE, `cnt` 0, `cur_dir` 0.
- Asserting reset mid-operation clears all state immediately. Any held step is discarded.

## Timing
- Latency: a `keycode` change sampled at edge N makes `move_valid` rise after edge N+1, i.e. 2 cycles.
- A held key produces steps at offsets 0, `REPEAT_DELAY`, `REPEAT_DELAY` + `REPEAT_RATE`, and so on, in cycles from the first step.
- Release is seen 2 cycles after `keycode` goes to 0. No step is emitted on or after release, even if `cnt` = 0 in the same cycle, because release takes priority.
- A direction change takes priority over `cnt` = 0.
- An accept and a new step in the same cycle produce back-to-back valid with no bubble.
- With `move_ready` tied high, `move_valid` is a single-cycle pulse per step.
- Same direction appearing in the other slot, with no net direction change: the repeat timing continues and no restart occurs.

## Test plan
Benches use `REPEAT_DELAY` = 8, `REPEAT_RATE` = 4 and `move_ready` = 1 unless noted.

- Reset check: hold reset 3 cycles with `keycode` = 16'h001A → `move_valid` = 0 and `drop_cnt` = 0 throughout. After release, exactly one step with `move_dir` = 0 appears 2 cycles later.
- Hold and repeat: `keycode` = 16'h0007 held for 30 cycles → steps with dir 3 at relative cycles 0, 8, 12, 16, 20, 24, 28. After `keycode` = 0, no further steps.
- Slot priority and change: 16'h0416 gives dir 2 (slot0 = S). A switch to 16'h1604 gives one immediate dir-1 step and the repeat delay restarts (next step 8 cycles later).
- Non-direction code: 16'h2C00 (space in slot1, slot0 empty) → no step and state stays IDLE. 16'h1A2C → dir 0 step, since slot1 matches.
- Backpressure: `move_ready` = 0 while 16'h0004 is held for 40 cycles → `move_valid` = 1 and `move_dir` = 1 are stable. `drop_cnt` = 8, from the repeats at 8, 12, …, 36. Raising `move_ready` accepts one step.
- Reset mid-hold: assert reset during REPEAT with `move_valid` = 1 → outputs clear on the same cycle. After release with the key still held, the first step appears at 2 cycles and the first repeat 8 cycles after that.
